// File: rtl/wb_stepper_pkg.sv
// Shared definitions for the Wishbone stepper controller: register map,
// CTRL/STATUS bit positions, FSM encoding and the gap-length helper.
package wb_stepper_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PERIOD   = 3'd1;
    localparam logic [2:0] REG_STEPS    = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_POSITION = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_ENABLE = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Low-time of one step: effective period is max(period, pulse+1), so the gap is never below 1.
    function automatic logic [31:0] gap_cycles(input logic [31:0] period, input logic [31:0] pulse);
        return (period > pulse) ? (period - pulse) : 32'd1;
    endfunction

endpackage

// File: rtl/stepper_core.sv
// Step timing engine: IDLE/PULSE/GAP FSM with one shared cycle counter.
// start_i/abort_i are single-cycle requests; abort always wins.
module stepper_core
    import wb_stepper_pkg::*;
#(
    parameter int PULSE_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        dir_i,
    input  logic [15:0] steps_i,
    input  logic [31:0] period_i,
    output logic        step_o,
    output logic        dir_o,
    output logic        busy_o,
    output logic [15:0] remaining_o,
    output logic        done_set_o,
    output logic        done_clr_o,
    output logic        step_cnt_o,
    output logic [1:0]  state_o
);

    localparam logic [31:0] PULSE_LEN  = 32'(PULSE_CYCLES);
    localparam logic [31:0] PULSE_LAST = PULSE_LEN - 32'd1;

    logic [1:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] gap_q, gap_d;
    logic [15:0] rem_q, rem_d;
    logic        dir_q, dir_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        done_set_o = 1'b0;
        done_clr_o = 1'b0;
        step_cnt_o = 1'b0;
        if (abort_i) begin
            // A pulse cut short here is never counted; remaining is kept for software.
            state_d    = ST_IDLE;
            cnt_d      = 32'd0;
            done_set_o = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (steps_i != 16'd0) begin
                            state_d    = ST_PULSE;
                            cnt_d      = 32'd0;
                            rem_d      = steps_i;
                            dir_d      = dir_i;
                            gap_d      = gap_cycles(period_i, PULSE_LEN);
                            done_clr_o = 1'b1;
                        end else begin
                            done_set_o = 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d    = ST_GAP;
                        cnt_d      = 32'd0;
                        rem_d      = rem_q - 16'd1;
                        step_cnt_o = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == gap_q - 32'd1) begin
                        cnt_d = 32'd0;
                        if (rem_q != 16'd0) begin
                            state_d = ST_PULSE;
                        end else begin
                            state_d    = ST_IDLE;
                            done_set_o = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
            gap_q   <= 32'd1;
            rem_q   <= 16'd0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    assign step_o      = (state_q == ST_PULSE);
    assign busy_o      = (state_q != ST_IDLE);
    assign dir_o       = dir_q;
    assign remaining_o = rem_q;
    assign state_o     = state_q;

endmodule

// File: rtl/wb_stepper.sv
// Wishbone stepper-motor controller: register file and bus slave around stepper_core.
// Define WB_STEPPER_IRQ_EN to build the DONE interrupt (CTRL bit4 and intr).
module wb_stepper
    import wb_stepper_pkg::*;
#(
    parameter int clk_freq     = 50000000,
    parameter int PULSE_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        step,
    output logic        dir,
    output logic        en_n,
    output logic        intr
);

    logic        ack_q;
    logic [31:0] dat_q;
    logic        ctrl_dir_q, ctrl_en_q;
    logic [31:0] period_q;
    logic [15:0] steps_q;
    logic [31:0] pos_q, pos_d;
    logic        done_q, done_d;
    logic [31:0] rd_data;

    logic        busy, done_set, done_clr, step_cnt;
    logic [15:0] remaining;
    logic [1:0]  core_state;

    // An access is taken on the cycle it is presented; the cycle after an ack never acks.
    logic       acc, wr;
    logic [2:0] reg_idx;
    assign acc     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr      = acc & wb_we_i;
    assign reg_idx = wb_adr_i[4:2];

    logic ctrl_wr, status_wr, pos_wr;
    assign ctrl_wr   = wr & (reg_idx == REG_CTRL);
    assign status_wr = wr & (reg_idx == REG_STATUS);
    assign pos_wr    = wr & (reg_idx == REG_POSITION);

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], core_state, 32'(clk_freq)};

    stepper_core #(.PULSE_CYCLES(PULSE_CYCLES)) u_core (
        .clk         (clk),
        .reset       (reset),
        .start_i     (ctrl_wr & wb_dat_i[CTRL_START] & ~wb_dat_i[CTRL_ABORT]),
        .abort_i     (ctrl_wr & wb_dat_i[CTRL_ABORT]),
        .dir_i       (wb_dat_i[CTRL_DIR]),
        .steps_i     (steps_q),
        .period_i    (period_q),
        .step_o      (step),
        .dir_o       (dir),
        .busy_o      (busy),
        .remaining_o (remaining),
        .done_set_o  (done_set),
        .done_clr_o  (done_clr),
        .step_cnt_o  (step_cnt),
        .state_o     (core_state)
    );

`ifdef WB_STEPPER_IRQ_EN
    logic ctrl_irq_q, intr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_irq_q <= 1'b0;
            intr_q     <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_irq_q <= wb_dat_i[CTRL_IRQ_EN];
            intr_q <= done_q & ctrl_irq_q;
        end
    end
    assign intr = intr_q;
`else
    assign intr = 1'b0;
`endif

    always_comb begin
        rd_data = 32'd0;
        case (reg_idx)
            REG_CTRL: begin
                rd_data[CTRL_DIR]    = ctrl_dir_q;
                rd_data[CTRL_ENABLE] = ctrl_en_q;
`ifdef WB_STEPPER_IRQ_EN
                rd_data[CTRL_IRQ_EN] = ctrl_irq_q;
`endif
            end
            REG_PERIOD:   rd_data = period_q;
            REG_STEPS:    rd_data = {16'd0, steps_q};
            REG_STATUS: begin
                rd_data[31:16]     = remaining;
                rd_data[STAT_DONE] = done_q;
                rd_data[STAT_BUSY] = busy;
            end
            REG_POSITION: rd_data = pos_q;
            default:      rd_data = 32'd0;
        endcase
    end

    // A completion or abort in the same cycle as a W1C leaves DONE set.
    always_comb begin
        done_d = done_q;
        if (status_wr && wb_dat_i[STAT_DONE]) done_d = 1'b0;
        if (done_clr) done_d = 1'b0;
        if (done_set) done_d = 1'b1;
    end

    always_comb begin
        pos_d = pos_q;
        if (step_cnt) begin
            pos_d = dir ? (pos_q + 32'd1) : (pos_q - 32'd1);
        end else if (pos_wr && !busy) begin
            pos_d = wb_dat_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            ctrl_dir_q <= 1'b0;
            ctrl_en_q  <= 1'b0;
            period_q   <= 32'd0;
            steps_q    <= 16'd0;
            pos_q      <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            ack_q <= acc;
            if (acc) dat_q <= rd_data;
            if (ctrl_wr) begin
                ctrl_dir_q <= wb_dat_i[CTRL_DIR];
                ctrl_en_q  <= wb_dat_i[CTRL_ENABLE];
            end
            if (wr && reg_idx == REG_PERIOD) period_q <= wb_dat_i;
            if (wr && reg_idx == REG_STEPS)  steps_q  <= wb_dat_i[15:0];
            pos_q  <= pos_d;
            done_q <= done_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign en_n     = ~ctrl_en_q;

endmodule

// File: doc/wb_stepper.md
WB_STEPPER -- requirements
Module: wb_stepper

Interface
REQ-001 SHALL have parameter clk_freq, default 50000000, system clock in Hz (informational, used for PULSE_CYCLES default).
REQ-002 SHALL have parameter PULSE_CYCLES, default 100, step-high width in clocks (2 us at 50 MHz); legal range 1..65535.
REQ-003 SHALL have ports:
  clk        in   1   system clock
  reset      in   1   async active-high reset
  wb_adr_i   in   32  Wishbone address, bits [4:2] decode register
  wb_dat_i   in   32  write data
  wb_dat_o   out  32  read data
  wb_sel_i   in   4   byte select, ignored (full-word access only)
  wb_stb_i   in   1   strobe
  wb_cyc_i   in   1   cycle
  wb_we_i    in   1   write enable
  wb_ack_o   out  1   acknowledge
  step       out  1   step pulse to driver
  dir        out  1   direction to driver, 1 = forward
  en_n       out  1   driver enable, active low
  intr       out  1   interrupt, active high

Function
REQ-004 SHALL ack every stb&cyc access one clock later as a single-cycle pulse; no ack on the cycle following an ack; wb_dat_o registered, valid with ack.
REQ-005 SHALL map registers: 0x00 CTRL, 0x04 PERIOD, 0x08 STEPS, 0x0C STATUS, 0x10 POSITION; other offsets read 0, writes ignored.
REQ-006 CTRL: bit0 START (write-1 pulse, reads 0), bit1 DIR, bit2 ABORT (write-1 pulse, reads 0), bit3 ENABLE (en_n = ~ENABLE), bit4 IRQ_EN.
REQ-007 PERIOD: 32-bit clocks per step; effective period = max(PERIOD, PULSE_CYCLES+1).
REQ-008 STEPS: 16-bit step count, bits [31:16] read 0.
REQ-009 STATUS: bit0 BUSY, bit1 DONE (sticky; write 1 to bit1 clears), bits [31:16] remaining steps.
REQ-010 POSITION: signed 32-bit, writable only when IDLE (writes while busy ignored); increments per forward step, decrements per reverse step, wraps modulo 2^32.
REQ-011 FSM states IDLE, PULSE, GAP.
REQ-012 IDLE + START with STEPS != 0 -> PULSE next cycle; latch DIR into dir output and STEPS into remaining; clear DONE.
REQ-013 IDLE + START with STEPS == 0 -> stay IDLE, set DONE next cycle.
REQ-014 PULSE: step = 1 for exactly PULSE_CYCLES clocks; on the last PULSE clock, remaining decrements and POSITION updates; -> GAP.
REQ-015 GAP: step = 0 for effective period - PULSE_CYCLES clocks; then -> PULSE if remaining != 0, else -> IDLE and set DONE.
REQ-016 START while BUSY SHALL be ignored; CTRL DIR writes while BUSY SHALL not alter dir until next start.
REQ-017 ABORT in any state SHALL force IDLE next cycle with step = 0; a partially emitted pulse is not counted; remaining retained; DONE set.
REQ-018 ABORT and START in the same write: ABORT wins, START ignored.
REQ-019 BUSY = 1 in PULSE and GAP.
REQ-020 DONE set and W1C clear in the same cycle: set wins.

Reset
REQ-021 On reset, asynchronously: FSM IDLE, step 0, dir 0, en_n 1, intr 0, wb_ack_o 0, wb_dat_o 0, all registers 0, DONE 0.
REQ-022 Reset mid-move SHALL abandon the move with no further step edges.

Configuration
REQ-023 With WB_STEPPER_IRQ_EN defined, intr = DONE & IRQ_EN (registered).
REQ-024 Without WB_STEPPER_IRQ_EN, intr SHALL be tied 0 and CTRL bit4 SHALL read 0; all else unchanged.

Structure
REQ-025 Register offsets, CTRL/STATUS bit indices and FSM state encoding SHALL live in shared package wb_stepper_pkg.
REQ-026 Step timing (PULSE/GAP counter and FSM) SHALL be a sub-module stepper_core; the Wishbone register file stays in wb_stepper.

Verification
REQ-027 PERIOD=1000, STEPS=3, DIR=1, START -> 3 pulses each 100 clocks high, rising edges 1000 clocks apart, POSITION=3, DONE=1, BUSY=0.
REQ-028 PERIOD=50 (below minimum), STEPS=2, START -> period 101 clocks, 100 high / 1 low.
REQ-029 STEPS=10, START, ABORT at mid-pulse 4 -> step low next cycle, remaining=7, POSITION=3, DONE=1.
REQ-030 STEPS=0, START -> no step edge, DONE=1 one cycle later; with IRQ_EN and macro defined, intr=1; W1C DONE -> intr=0.
REQ-031 POSITION=0x7FFFFFFF, DIR=1, STEPS=1 -> POSITION=0x80000000; POSITION write while BUSY ignored.
REQ-032 Back-to-back stb across all offsets -> ack pulses on alternate cycles, unmapped offset reads 0.
